button_events: RTL and testbench

- Sits directly downstream of the per-button debouncer and consumes its clean level.
- Converts the level into single-cycle event pulses: press, release, short click, long press, and auto-repeat while held.
- Drives the central FSM and menu logic, so those blocks never see raw levels.
- One instance per button; all timing is in clock cycles at 27 MHz.

---
 rtl/button_events_pkg.sv | 29 ++
 rtl/button_events_edge_detect.sv | 26 ++
 rtl/button_events.sv | 143 ++++++++++++++
 tb/tb_button_events.sv | 138 +++++++++++++
 4 files changed

// File: rtl/button_events_pkg.sv
// Shared definitions for button event generation: FSM encodings, default
// timing constants and the registered event bundle.
package button_events_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHORT = 2'd1,
        ST_LONG  = 2'd2
    } state_t;

    // Default timer constants at 27 MHz, reused by other timers.
    localparam int ONE_SEC           = 27_000_000;
    localparam int QUARTER_SEC       = 6_750_000;
    localparam int DEFAULT_CNT_WIDTH = 25;

    typedef struct packed {
        logic press;
        logic rel;
        logic click;
        logic long_press;
        logic rpt;
    } events_t;

    // Terminal counter value for a period of `period` cycles; 0 for a disabled period.
    function automatic int last_count(input int period);
        return (period > 0) ? period - 1 : 0;
    endfunction

endpackage

// File: rtl/button_events_edge_detect.sv
// Registers a level and flags rising/falling transitions against the
// registered copy. Reset loads the live level so no edge is seen on exit.
module button_events_edge_detect (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_level,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_level;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_level <= i_level;
        end else begin
            r_level <= i_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = i_level & ~r_level;
    assign o_fall  = ~i_level & r_level;

endmodule

// File: rtl/button_events.sv
// Turns a debounced button level into one-cycle press, release, click,
// long-press and auto-repeat pulses. All outputs are registered.
module button_events
    import button_events_pkg::*;
#(
    parameter bit ACTIVE_LOW    = 1'b0,
    parameter int LONG_DELAY    = ONE_SEC,
    parameter int REPEAT_PERIOD = QUARTER_SEC,
    parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clean,
    output logic o_held,
    output logic o_press,
    output logic o_release,
    output logic o_click,
    output logic o_long_press,
    output logic o_repeat
);

    localparam bit                   REPEAT_EN   = (REPEAT_PERIOD != 0);
    localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(last_count(LONG_DELAY));
    localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(last_count(REPEAT_PERIOD));

    logic w_btn;
    logic w_prev;
    logic w_rise;
    logic w_fall;
    logic w_long_hit;
    logic w_repeat_hit;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] w_count_next;
    logic                 r_blocked;
    logic                 w_blocked_next;
    events_t              r_events;
    events_t              w_events_next;

    assign w_btn = i_clean ^ ACTIVE_LOW;

    button_events_edge_detect u_edge (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_level (w_btn),
        .o_level (w_prev),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_long_hit   = (r_count == LONG_LAST);
    assign w_repeat_hit = REPEAT_EN && (r_count == REPEAT_LAST);

    // A button held through reset stays blocked until it is let go once.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_blocked <= w_btn;
            r_events  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_blocked <= w_blocked_next;
            r_events  <= w_events_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_blocked_next = r_blocked;
        case (r_state)
            ST_IDLE: begin
                w_count_next = '0;
                if (w_fall) begin
                    w_blocked_next = 1'b0;
                end
                if (w_rise && !r_blocked) begin
                    w_state_next = ST_SHORT;
                end
            end
            ST_SHORT: begin
                if (w_fall) begin
                    w_state_next = ST_IDLE;
                    w_count_next = '0;
                end else if (w_long_hit) begin
                    w_state_next = ST_LONG;
                    w_count_next = '0;
                end else begin
                    w_count_next = r_count + CNT_WIDTH'(1);
                end
            end
            ST_LONG: begin
                // With repeat disabled the counter parks at 0 instead of running free.
                if (w_fall) begin
                    w_state_next = ST_IDLE;
                    w_count_next = '0;
                end else if (!REPEAT_EN || w_repeat_hit) begin
                    w_count_next = '0;
                end else begin
                    w_count_next = r_count + CNT_WIDTH'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_count_next = '0;
            end
        endcase
    end

    // A fall always beats a threshold reached in the same cycle.
    always_comb begin
        w_events_next = '0;
        case (r_state)
            ST_IDLE: begin
                w_events_next.press = w_rise && !r_blocked;
            end
            ST_SHORT: begin
                w_events_next.rel        = w_fall;
                w_events_next.click      = w_fall;
                w_events_next.long_press = !w_fall && w_long_hit;
            end
            ST_LONG: begin
                w_events_next.rel = w_fall;
                w_events_next.rpt = !w_fall && w_repeat_hit;
            end
            default: begin
                w_events_next = '0;
            end
        endcase
    end

    assign o_held       = w_prev;
    assign o_press      = r_events.press;
    assign o_release    = r_events.rel;
    assign o_click      = r_events.click;
    assign o_long_press = r_events.long_press;
    assign o_repeat     = r_events.rpt;

endmodule

// File: tb/tb_button_events.sv
// Drives three button_events instances (active-high, active-low, repeat off)
// with one logical button level and compares every cycle to a hold-time model.
module tb_button_events;

    localparam int LD = 10;
    localparam int RP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] clean = 3'b000;
    logic [2:0] held, press, rel, click, lng, rpt;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    button_events #(.ACTIVE_LOW(1'b0), .LONG_DELAY(LD), .REPEAT_PERIOD(RP), .CNT_WIDTH(8)) u_dut0 (
        .i_clock(clk), .i_reset(rst), .i_clean(clean[0]), .o_held(held[0]), .o_press(press[0]),
        .o_release(rel[0]), .o_click(click[0]), .o_long_press(lng[0]), .o_repeat(rpt[0]));

    button_events #(.ACTIVE_LOW(1'b1), .LONG_DELAY(LD), .REPEAT_PERIOD(RP), .CNT_WIDTH(8)) u_dut1 (
        .i_clock(clk), .i_reset(rst), .i_clean(clean[1]), .o_held(held[1]), .o_press(press[1]),
        .o_release(rel[1]), .o_click(click[1]), .o_long_press(lng[1]), .o_repeat(rpt[1]));

    button_events #(.ACTIVE_LOW(1'b0), .LONG_DELAY(LD), .REPEAT_PERIOD(0), .CNT_WIDTH(8)) u_dut2 (
        .i_clock(clk), .i_reset(rst), .i_clean(clean[2]), .o_held(held[2]), .o_press(press[2]),
        .o_release(rel[2]), .o_click(click[2]), .o_long_press(lng[2]), .o_repeat(rpt[2]));

    // Reference model: pressed level, whether a hold is being timed, and how
    // many cycles that hold has lasted since its press was accepted.
    logic m_prev    = 1'b0;
    logic m_blocked = 1'b0;
    logic m_active  = 1'b0;
    logic m_fired   = 1'b0;
    int   m_t       = 0;
    logic e_held, e_press, e_rel, e_click, e_long, e_rpt;

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s cycle %0d: got {held,press,rel,click,long,rpt}=%b expected %b",
                     tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input logic b, input logic r);
        e_press = 0; e_rel = 0; e_click = 0; e_long = 0; e_rpt = 0;
        if (r) begin
            m_active  = 0;
            m_blocked = b;
        end else if (!m_active) begin
            if (!b) m_blocked = 0;
            if (b && !m_prev && !m_blocked) begin
                e_press  = 1;
                m_active = 1;
                m_fired  = 0;
                m_t      = 0;
            end
        end else if (!b) begin
            e_rel    = 1;
            e_click  = !m_fired;
            m_active = 0;
        end else begin
            m_t++;
            if (m_t == LD) begin
                e_long  = 1;
                m_fired = 1;
            end else if (m_t > LD && ((m_t - LD) % RP) == 0) begin
                e_rpt = 1;
            end
        end
        m_prev = b;
        e_held = b;
    endtask

    task automatic tick(input logic lvl, input logic r);
        @(negedge clk);
        rst   = r;
        clean = {lvl, ~lvl, lvl};
        @(posedge clk);
        cyc++;
        model_step(lvl, r);
        #1;
        check("act_high", {held[0], press[0], rel[0], click[0], lng[0], rpt[0]},
              {e_held, e_press, e_rel, e_click, e_long, e_rpt});
        check("act_low", {held[1], press[1], rel[1], click[1], lng[1], rpt[1]},
              {e_held, e_press, e_rel, e_click, e_long, e_rpt});
        check("no_repeat", {held[2], press[2], rel[2], click[2], lng[2], rpt[2]},
              {e_held, e_press, e_rel, e_click, e_long, 1'b0});
    endtask

    task automatic run(input logic lvl, input int n, input logic r);
        for (int i = 0; i < n; i++) tick(lvl, r);
    endtask

    initial begin
        logic lvl;
        // Short click, long hold with repeats, fall on the threshold cycle.
        run(0, 3, 1);
        run(0, 3, 0);
        run(1, 5, 0);
        run(0, 5, 0);
        run(1, 25, 0);
        run(0, 5, 0);
        run(1, 10, 0);
        run(0, 5, 0);
        // Held through reset, released later, then a normal press.
        run(1, 2, 1);
        run(1, 20, 0);
        run(0, 4, 0);
        run(1, 40, 0);
        run(0, 3, 0);
        // Reset in the middle of a long hold.
        run(1, 15, 0);
        run(1, 1, 1);
        run(1, 12, 0);
        run(0, 3, 0);

        lvl = 1'b0;
        for (int s = 0; s < 250; s++) begin
            if ($urandom_range(0, 19) == 0) begin
                lvl = 1'($urandom_range(0, 1));
                run(lvl, $urandom_range(1, 3), 1);
            end else begin
                lvl = ~lvl;
                run(lvl, $urandom_range(1, 35), 0);
            end
        end
        run(0, 3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
